// File: rtl/quote_order_enc_pkg.sv
// rtl/quote_order_enc_pkg.sv - shared types and constants for the quote order encoder
//
// Purpose : message header byte, FSM state type, quote record type and the
//           message length helper used by quote_order_encoder.
// Macro   : QUOTE_ORDER_ENC_CHECKSUM_EN adds one trailing XOR checksum byte.
// Ports   : none (package).

package quote_order_enc_pkg;

  localparam logic [7:0] ORDER_HEADER = 8'hA5;

  // Price width carried in the buffered quote record; the encoder's
  // DATA_WIDTH parameter must match it.
  localparam int QUOTE_DATA_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Stock id is stored as a full byte: it goes onto the wire zero-extended.
  typedef struct packed {
    logic [7:0]                  stock_id;
    logic [QUOTE_DATA_WIDTH-1:0] buy_price;
    logic [QUOTE_DATA_WIDTH-1:0] sell_price;
  } quote_t;

  // Header + seq + stock id + both prices (+ optional checksum byte).
  function automatic int msg_len(input int data_width);
`ifdef QUOTE_ORDER_ENC_CHECKSUM_EN
    return 4 + 2 * (data_width / 8);
`else
    return 3 + 2 * (data_width / 8);
`endif
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with full/empty flags
//
// Purpose : buffers quote records between the no-backpressure quote input
//           and the message serialiser. Show-ahead: o_pop_data is the head.
// Ports   : i_clk, i_reset (sync, active-high), i_push/i_push_data,
//           i_pop, o_pop_data, o_full, o_empty.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when addresses match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  logic do_push;
  logic do_pop;

  assign do_push    = i_push && !o_full;
  assign do_pop     = i_pop && !o_empty;
  assign o_empty    = (wr_ptr == rd_ptr);
  assign o_full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

endmodule

// File: rtl/quote_order_encoder.sv
// rtl/quote_order_encoder.sv - serialises trading quotes into byte messages
//
// Purpose : buffers quotes in a small FIFO (drops and counts on overflow) and
//           emits each as a big-endian message on a valid/ready byte stream:
//           A5, seq, stock id, buy price, sell price [, XOR checksum].
// Macro   : QUOTE_ORDER_ENC_CHECKSUM_EN appends the checksum byte.
// Ports   : i_clk, i_reset (sync, active-high)
//           quote in  : i_buy_price, i_sell_price, i_stock_id, i_data_valid
//           byte out  : o_tdata, o_tvalid, i_tready, o_tlast
//           status    : o_overflow (pulse), o_drop_count (saturating), o_busy

module quote_order_encoder
  import quote_order_enc_pkg::*;
#(
  parameter int DATA_WIDTH = QUOTE_DATA_WIDTH,
  parameter int NUM_STOCKS = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [DATA_WIDTH-1:0]         i_buy_price,
  input  logic [DATA_WIDTH-1:0]         i_sell_price,
  input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
  input  logic                          i_data_valid,
  output logic [7:0]                    o_tdata,
  output logic                          o_tvalid,
  input  logic                          i_tready,
  output logic                          o_tlast,
  output logic                          o_overflow,
  output logic [15:0]                   o_drop_count,
  output logic                          o_busy
);

  localparam int MSG_LEN = msg_len(DATA_WIDTH);
  localparam int MSG_W   = MSG_LEN * 8;
  localparam int IDX_W   = $clog2(MSG_LEN);

  state_t           state;
  logic [7:0]       seq;
  logic [IDX_W-1:0] idx;
  // Bytes still to be presented after the one currently on o_tdata, MSB first.
  logic [MSG_W-9:0] rest;

  quote_t     push_q;
  quote_t     head_q;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       drop;
  logic       hs;
  logic       msg_done;
  logic       load;
  logic [7:0] load_seq;
  logic [MSG_W-1:0] load_msg;

  // Builds the complete message image, byte 0 in the top bits.
  function automatic logic [MSG_W-1:0] build_msg(input quote_t q, input logic [7:0] s);
    logic [MSG_W-1:0] m;
    m = '0;
    m[MSG_W-1  -: 8] = ORDER_HEADER;
    m[MSG_W-9  -: 8] = s;
    m[MSG_W-17 -: 8] = q.stock_id;
    m[MSG_W-25 -: DATA_WIDTH]            = q.buy_price[DATA_WIDTH-1:0];
    m[MSG_W-25-DATA_WIDTH -: DATA_WIDTH] = q.sell_price[DATA_WIDTH-1:0];
`ifdef QUOTE_ORDER_ENC_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < MSG_LEN - 1; i++) begin
        x = x ^ m[MSG_W-1-8*i -: 8];
      end
      m[7:0] = x;
    end
`endif
    return m;
  endfunction

  assign push_q.stock_id   = 8'(i_stock_id);
  assign push_q.buy_price  = i_buy_price;
  assign push_q.sell_price = i_sell_price;

  // Full is judged on this cycle's occupancy, so a same-cycle pop does not
  // make room for a quote arriving while full.
  assign push = i_data_valid && !fifo_full;
  assign drop = i_data_valid && fifo_full;

  assign hs       = o_tvalid && i_tready;
  assign msg_done = hs && o_tlast;
  // Load from IDLE, or chain straight into the next message on the last
  // handshake so back-to-back messages have no bubble.
  assign load     = ((state == IDLE) || msg_done) && !fifo_empty;
  // When chaining, the sequence register increments on this same edge.
  assign load_seq = (state == SEND) ? seq + 8'd1 : seq;
  assign load_msg = build_msg(head_q, load_seq);

  assign o_busy = !fifo_empty || (state == SEND);

  sync_fifo #(
    .WIDTH ($bits(quote_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (push),
    .i_push_data (push_q),
    .i_pop       (load),
    .o_pop_data  (head_q),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      seq          <= 8'd0;
      idx          <= '0;
      rest         <= '0;
      o_tdata      <= 8'd0;
      o_tvalid     <= 1'b0;
      o_tlast      <= 1'b0;
      o_overflow   <= 1'b0;
      o_drop_count <= 16'd0;
    end else begin
      o_overflow <= drop;
      if (drop && (o_drop_count != 16'hFFFF)) begin
        o_drop_count <= o_drop_count + 16'd1;
      end

      if (msg_done) begin
        seq <= seq + 8'd1;
      end

      if (load) begin
        state    <= SEND;
        o_tvalid <= 1'b1;
        o_tdata  <= load_msg[MSG_W-1 -: 8];
        rest     <= load_msg[MSG_W-9:0];
        idx      <= '0;
        o_tlast  <= 1'b0;
      end else if (msg_done) begin
        state    <= IDLE;
        o_tvalid <= 1'b0;
        o_tlast  <= 1'b0;
      end else if (hs) begin
        o_tdata <= rest[MSG_W-9 -: 8];
        rest    <= rest << 8;
        idx     <= idx + 1'b1;
        // idx names the byte just accepted; the next one is last at MSG_LEN-1.
        o_tlast <= (idx == IDX_W'(MSG_LEN - 2));
      end
    end
  end

endmodule
